// File: rtl/rc4_key_search_core.sv
// RC4 key-search core: for each key in [key_first, key_last] runs KSA and PRGA over an
// external S-RAM, decrypts the ciphertext ROM into D-RAM, and aborts keys on non-printable output.
module rc4_key_search_core #(
  parameter int KEY_BYTES = 3,
  parameter int KEY_BITS  = 24,
  parameter int MSG_LEN   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                search_en,
  input  logic [KEY_BITS-1:0] key_first,
  input  logic [KEY_BITS-1:0] key_last,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [KEY_BITS-1:0] key_out,
  output logic [7:0]          s_addr,
  output logic [7:0]          s_wdata,
  output logic                s_wren,
  input  logic [7:0]          s_rdata,
  output logic [7:0]          e_addr,
  input  logic [7:0]          e_rdata,
  output logic [7:0]          d_addr,
  output logic [7:0]          d_wdata,
  output logic                d_wren
);

  localparam int          KW        = 8 * KEY_BYTES;
  localparam logic [2:0]  KIDX_LAST = 3'(KEY_BYTES - 1);
  localparam logic [7:0]  K_LAST    = 8'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_INIT,
    ST_WAIT_I, ST_CAP_I, ST_WAIT_J, ST_CAP_J, ST_WR_I, ST_WR_J,
    ST_WAIT_T, ST_CAP_T, ST_WR_D, ST_NEXT_KEY, ST_DONE
  } state_t;

  state_t              r_state;
  logic                r_search;
  logic [KEY_BITS-1:0] r_key_last;
  logic [7:0]          r_i, r_j, r_si, r_sj, r_k;
  logic [2:0]          r_kidx;
  logic                r_prga;
  logic                r_all_valid;

  logic [KW-1:0]       w_key_ext;
  logic [7:0]          w_key_byte;
  logic [7:0]          w_j_next;
  logic [7:0]          w_d;
  logic                w_valid;
  logic                w_final_ok;

  assign w_key_ext = KW'(key_out);

  // keybyte[0] is the most-significant byte of the zero-extended key.
  always_comb begin
    // NOTE: default first so every path assigns w_key_byte and no latch is inferred.
    w_key_byte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++)
      if (r_kidx == 3'(n)) w_key_byte = w_key_ext[8*(KEY_BYTES-1-n) +: 8];
  end

  assign w_j_next = r_j + s_rdata + (r_prga ? 8'h00 : w_key_byte);
  assign w_d      = s_rdata ^ e_rdata;
  assign w_valid  = (w_d >= 8'h61 && w_d <= 8'h7A) || (w_d == 8'h20);

  // A successful last byte (being decided or being written) takes priority over stop.
  assign w_final_ok = (r_k == K_LAST) &&
                      (((r_state == ST_CAP_T) && w_valid && r_all_valid) ||
                       ((r_state == ST_WR_D) && r_all_valid));

  // NOTE: state and registered outputs use non-blocking assignments so every read sees
  // the pre-edge value; the external RAMs hold the S/D contents and are never cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      key_out     <= '0;
      s_addr      <= 8'h00;
      s_wdata     <= 8'h00;
      s_wren      <= 1'b0;
      e_addr      <= 8'h00;
      d_addr      <= 8'h00;
      d_wdata     <= 8'h00;
      d_wren      <= 1'b0;
      r_search    <= 1'b0;
      r_key_last  <= '0;
      r_i         <= 8'h00;
      r_j         <= 8'h00;
      r_si        <= 8'h00;
      r_sj        <= 8'h00;
      r_k         <= 8'h00;
      r_kidx      <= 3'd0;
      r_prga      <= 1'b0;
      r_all_valid <= 1'b0;
    end else begin
      s_wren <= 1'b0;
      d_wren <= 1'b0;
      if (r_state == ST_IDLE || r_state == ST_DONE) begin
        if (start) begin
          r_search   <= search_en;
          key_out    <= key_first;
          r_key_last <= key_last;
          busy       <= 1'b1;
          done       <= 1'b0;
          found      <= 1'b0;
          r_state    <= ST_START;
        end
      end else if (stop && !w_final_ok) begin
        r_state <= ST_DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        found   <= 1'b0;
      end else begin
        case (r_state)
          ST_START, ST_NEXT_KEY: begin
            if ((r_state == ST_START && key_out > r_key_last) ||
                (r_state == ST_NEXT_KEY && key_out == r_key_last)) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              found   <= 1'b0;
            end else begin
              if (r_state == ST_NEXT_KEY) key_out <= key_out + KEY_BITS'(1);
              s_addr  <= 8'h00;
              s_wdata <= 8'h00;
              s_wren  <= 1'b1;
              r_state <= ST_INIT;
            end
          end
          ST_INIT: begin
            if (s_addr == 8'hFF) begin
              s_addr  <= 8'h00;
              r_i     <= 8'h00;
              r_j     <= 8'h00;
              r_kidx  <= 3'd0;
              r_prga  <= 1'b0;
              r_state <= ST_WAIT_I;
            end else begin
              s_addr  <= s_addr + 8'h01;
              s_wdata <= s_addr + 8'h01;
              s_wren  <= 1'b1;
            end
          end
          ST_WAIT_I: r_state <= ST_CAP_I;
          ST_CAP_I: begin
            r_si    <= s_rdata;
            r_j     <= w_j_next;
            s_addr  <= w_j_next;
            r_state <= ST_WAIT_J;
          end
          ST_WAIT_J: r_state <= ST_CAP_J;
          ST_CAP_J: begin
            // Both old values are held, so i == j writes the same byte back twice.
            r_sj    <= s_rdata;
            s_addr  <= r_i;
            s_wdata <= s_rdata;
            s_wren  <= 1'b1;
            r_state <= ST_WR_I;
          end
          ST_WR_I: begin
            s_addr  <= r_j;
            s_wdata <= r_si;
            s_wren  <= 1'b1;
            r_state <= ST_WR_J;
          end
          ST_WR_J: begin
            if (r_prga) begin
              s_addr  <= r_si + r_sj;
              r_state <= ST_WAIT_T;
            end else if (r_i == 8'hFF) begin
              r_prga      <= 1'b1;
              r_i         <= 8'h01;
              r_j         <= 8'h00;
              r_k         <= 8'h00;
              e_addr      <= 8'h00;
              r_all_valid <= 1'b1;
              s_addr      <= 8'h01;
              r_state     <= ST_WAIT_I;
            end else begin
              r_i     <= r_i + 8'h01;
              s_addr  <= r_i + 8'h01;
              r_kidx  <= (r_kidx == KIDX_LAST) ? 3'd0 : r_kidx + 3'd1;
              r_state <= ST_WAIT_I;
            end
          end
          ST_WAIT_T: r_state <= ST_CAP_T;
          ST_CAP_T: begin
            if (r_search && !w_valid) begin
              r_state <= ST_NEXT_KEY;
            end else begin
              d_addr      <= r_k;
              d_wdata     <= w_d;
              d_wren      <= 1'b1;
              r_all_valid <= r_all_valid & w_valid;
              r_state     <= ST_WR_D;
            end
          end
          ST_WR_D: begin
            if (r_k == K_LAST) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              found   <= r_all_valid;
            end else begin
              r_k     <= r_k + 8'h01;
              e_addr  <= r_k + 8'h01;
              r_i     <= r_i + 8'h01;
              s_addr  <= r_i + 8'h01;
              r_state <= ST_WAIT_I;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_key_search_core.sv
// Self-checking bench for rc4_key_search_core: memory models plus a plain RC4 reference
// model, exercising single decrypt, key search, range limits, stop, restart and reset.
module tb_rc4_key_search_core;

  localparam int KEY_BYTES = 3;
  localparam int KEY_BITS  = 24;
  localparam int MSG_LEN   = 32;
  localparam int TIMEOUT   = 30000;

  logic                clk = 1'b0;
  logic                reset, start, search_en, stop;
  logic [KEY_BITS-1:0] key_first, key_last;
  logic                busy, done, found;
  logic [KEY_BITS-1:0] key_out;
  logic [7:0]          s_addr, s_wdata, s_rdata, e_addr, e_rdata, d_addr, d_wdata;
  logic                s_wren, d_wren;

  logic [7:0] s_mem [256];
  logic [7:0] e_rom [256];
  logic [7:0] d_mem [256];
  logic [7:0] ks    [MSG_LEN];
  logic [7:0] plain [MSG_LEN];

  int   checks = 0;
  int   errors = 0;
  int   init_passes, bad_d_writes;
  logic clr = 1'b0;
  logic count_bad = 1'b0;
  logic       p1_w = 1'b0, p2_w = 1'b0;
  logic [7:0] p1_a, p1_d, p2_a, p2_d;

  rc4_key_search_core #(.KEY_BYTES(KEY_BYTES), .KEY_BITS(KEY_BITS), .MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .search_en(search_en),
    .key_first(key_first), .key_last(key_last), .stop(stop),
    .busy(busy), .done(done), .found(found), .key_out(key_out),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .e_addr(e_addr), .e_rdata(e_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren)
  );

  always #5 clk = ~clk;

  function automatic bit is_valid(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
  endfunction

  // Memories with one-cycle registered reads; an INIT pass is recognised as three
  // consecutive identity writes 0,1,2 (KSA/PRGA never write three cycles in a row).
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wdata;
    s_rdata <= s_mem[s_addr];
    e_rdata <= e_rom[e_addr];
    if (clr) begin
      init_passes  <= 0;
      bad_d_writes <= 0;
      for (int a = 0; a < 256; a++) d_mem[a] <= 8'h00;
    end else begin
      if (d_wren) begin
        d_mem[d_addr] <= d_wdata;
        if (count_bad && !is_valid(d_wdata)) bad_d_writes <= bad_d_writes + 1;
      end
      if (s_wren && s_addr == 8'd2 && s_wdata == 8'd2 && p1_w && p1_a == 8'd1 && p1_d == 8'd1 &&
          p2_w && p2_a == 8'd0 && p2_d == 8'd0)
        init_passes <= init_passes + 1;
    end
    p2_w <= p1_w; p2_a <= p1_a; p2_d <= p1_d;
    p1_w <= s_wren; p1_a <= s_addr; p1_d <= s_wdata;
  end

  // Textbook RC4: keystream for the first MSG_LEN bytes.
  function automatic void model_ks(input logic [23:0] key);
    int s [256];
    int i, j, t, kb;
    for (i = 0; i < 256; i++) s[i] = i;
    j = 0;
    for (i = 0; i < 256; i++) begin
      kb = int'((key >> (8 * (KEY_BYTES - 1 - (i % KEY_BYTES)))) & 24'hFF);
      j = (j + s[i] + kb) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[k] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endfunction

  function automatic bit key_ok(input logic [23:0] key);
    model_ks(key);
    for (int k = 0; k < MSG_LEN; k++)
      if (!is_valid(e_rom[k] ^ ks[k])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_search(input longint first, input longint last,
                              output bit f, output logic [23:0] k);
    f = 1'b0;
    k = last[23:0];
    for (longint kk = first; kk <= last; kk++)
      if (key_ok(kk[23:0])) begin
        f = 1'b1;
        k = kk[23:0];
        return;
      end
  endtask

  task automatic load_cipher_for(input logic [23:0] key);
    int r;
    model_ks(key);
    for (int a = 0; a < 256; a++) e_rom[a] = 8'($urandom);
    for (int k = 0; k < MSG_LEN; k++) begin
      r = int'($urandom_range(0, 26));
      plain[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      e_rom[k] = plain[k] ^ ks[k];
    end
  endtask

  task automatic clear_monitors();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic start_run(input logic [23:0] first, input logic [23:0] last, input logic srch);
    @(negedge clk);
    key_first = first; key_last = last; search_en = srch; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, TIMEOUT);
    end
  endtask

  task automatic check_plain(input string name, input logic [23:0] key);
    model_ks(key);
    for (int k = 0; k < MSG_LEN; k++) begin
      checks++;
      if (d_mem[k] !== (e_rom[k] ^ ks[k])) begin
        errors++;
        $display("FAIL %s d[%0d]: got %h expected %h", name, k, d_mem[k], e_rom[k] ^ ks[k]);
      end
    end
  endtask

  task automatic check_result(input string name, input logic f_exp, input logic [23:0] k_exp);
    checks++;
    if ({done, busy, found, key_out} !== {1'b1, 1'b0, f_exp, k_exp}) begin
      errors++;
      $display("FAIL %s result: done/busy/found/key got %b%b%b/%h expected 10%b/%h",
               name, done, busy, found, key_out, f_exp, k_exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, found, key_out, s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren} !== '0) begin
      errors++;
      $display("FAIL %s outputs: busy=%b done=%b found=%b key=%h s_addr=%h s_wren=%b d_wren=%b expected all 0",
               name, busy, done, found, key_out, s_addr, s_wren, d_wren);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; search_en = 1'b0;
    key_first = '0; key_last = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_single_known();
    load_cipher_for(24'h000249);
    clear_monitors();
    start_run(24'h000249, 24'h000249, 1'b0);
    wait_done("single_known");
    check_plain("single_known", 24'h000249);
    check_result("single_known", 1'b1, 24'h000249);
    checks++;
    if (init_passes !== 1) begin
      errors++;
      $display("FAIL single_known init passes: got %0d expected 1", init_passes);
    end
  endtask

  task automatic test_single_random();
    logic [23:0] key;
    bit ok;
    key = 24'($urandom);
    for (int a = 0; a < 256; a++) e_rom[a] = 8'($urandom);
    ok = key_ok(key);
    clear_monitors();
    start_run(key, key, 1'b0);
    wait_done("single_random");
    check_plain("single_random", key);
    check_result("single_random", ok, key);
  endtask

  task automatic test_search(input string name, input logic [23:0] first, input logic [23:0] last);
    bit f_exp;
    logic [23:0] k_exp;
    int passes_exp;
    model_search(longint'(first), longint'(last), f_exp, k_exp);
    passes_exp = int'(k_exp) - int'(first) + 1;
    clear_monitors();
    count_bad = 1'b1;
    start_run(first, last, 1'b1);
    wait_done(name);
    count_bad = 1'b0;
    check_result(name, f_exp, k_exp);
    checks++;
    if (init_passes !== passes_exp) begin
      errors++;
      $display("FAIL %s init passes: got %0d expected %0d", name, init_passes, passes_exp);
    end
    checks++;
    if (bad_d_writes !== 0) begin
      errors++;
      $display("FAIL %s invalid bytes written: got %0d expected 0", name, bad_d_writes);
    end
    if (f_exp) check_plain(name, k_exp);
  endtask

  task automatic test_reversed();
    start_run(24'h000010, 24'h000005, 1'b1);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL reversed accept: busy/done got %b%b expected 10", busy, done);
    end
    @(negedge clk);
    check_result("reversed", 1'b0, 24'h000010);
  endtask

  task automatic test_stop_and_restart();
    start_run(24'h000100, 24'h0001FF, 1'b1);
    repeat (600) @(negedge clk);
    key_first = 24'h000555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, key_out} !== {2'b10, 24'h000100}) begin
      errors++;
      $display("FAIL start_ignored: busy/done/key got %b%b/%h expected 10/000100", busy, done, key_out);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_result("stop_mid_ksa", 1'b0, 24'h000100);
    checks++;
    if ({s_wren, d_wren} !== 2'b00) begin
      errors++;
      $display("FAIL stop_wren: s_wren/d_wren got %b%b expected 00", s_wren, d_wren);
    end
    start_run(24'h000249, 24'h000249, 1'b0);
    checks++;
    if ({busy, done, found} !== 3'b100) begin
      errors++;
      $display("FAIL restart: busy/done/found got %b%b%b expected 100", busy, done, found);
    end
  endtask

  task automatic test_reset_mid_prga();
    int n;
    n = 0;
    while (!d_wren && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!d_wren) begin
      errors++;
      $display("FAIL reset_mid_prga: no D write within %0d cycles", TIMEOUT);
    end
    #2 reset = 1'b1;
    #1 check_all_zero("reset_mid_prga");
    @(negedge clk);
    reset = 1'b0;
    clear_monitors();
    start_run(24'h000249, 24'h000249, 1'b0);
    wait_done("after_reset");
    check_plain("after_reset", 24'h000249);
    check_result("after_reset", 1'b1, 24'h000249);
  endtask

  initial begin
    test_reset();
    test_single_known();
    test_search("search_hit", 24'h000240, 24'h00024F);
    test_search("search_none", 24'h000000, 24'h000003);
    test_search("top_key", 24'hFFFFFF, 24'hFFFFFF);
    test_reversed();
    test_single_random();
    load_cipher_for(24'h000249);
    test_stop_and_restart();
    test_reset_mid_prga();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_key_search_core.md
Name: rc4_key_search_core

Overview:
Parametrised successor to the single-key decryption core. Runs RC4 KSA and PRGA over an encrypted message for a range of keys. In search mode it aborts a key on the first non-printable plaintext byte and advances to the next key; in single mode it decrypts one key fully. Several instances partition the key space at top level and share a stop line.

Parameters:
KEY_BYTES, 3, number of secret-key bytes cycled during KSA (1..8)
KEY_BITS, 24, significant key bits; upper 8*KEY_BYTES-KEY_BITS bits forced 0
MSG_LEN, 32, encrypted/decrypted message length in bytes (1..256)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; sampled only in IDLE or DONE
search_en  in  1  1=key search with early abort, 0=single-key decrypt; latched on start
key_first  in  KEY_BITS  first key tried; latched on start
key_last  in  KEY_BITS  last key tried, inclusive; latched on start
stop  in  1  external abort, e.g. another core found the key
busy  out  1  high from accepted start until DONE
done  out  1  level; high in DONE until next accepted start or reset
found  out  1  valid when done; 1=key_out produced all-valid plaintext
key_out  out  KEY_BITS  key being tried; final/found key when done
s_addr, s_wdata  out  8,8  S-RAM interface, 256x8
s_wren  out  1  S-RAM write enable
s_rdata  in  8  S-RAM read data, 1-cycle registered latency
e_addr  out  8  encrypted ROM address
e_rdata  in  8  encrypted ROM data, 1-cycle latency
d_addr, d_wdata  out  8,8  decrypted RAM interface
d_wren  out  1  decrypted RAM write enable

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, found, s_wren, d_wren=0; key_out, all addresses/wdata=0. Memory contents are not cleared.
- Start acceptance:
  - start in IDLE/DONE latches search_en, key_first, key_last; sets key_out=key_first, busy=1, done=0, found=0.
  - start while busy is ignored.
  - If key_first>key_last: go to DONE next cycle with found=0.
- States: IDLE -> INIT -> KSA -> PRGA -> (NEXT_KEY -> INIT | DONE).
- INIT: write s[i]=i for i=0..255, one write per cycle, exactly 256 cycles.
- KSA, i=0..255:
  - j=(j+s[i]+keybyte[i mod KEY_BYTES]) mod 256, all arithmetic 8-bit wrapping, j=0 at entry.
  - keybyte[0] is the most-significant byte of the zero-extended key.
  - Read s[i], read s[j], write s[i]=old s[j], write s[j]=old s[i].
  - Must be correct when i==j: s unchanged.
- PRGA, k=0..MSG_LEN-1, i=0 and j=0 at entry:
  - i=i+1; j=j+s[i]; swap s[i], s[j]; f=s[(s[i]+s[j]) mod 256]; d[k]=f XOR e[k]; write D.
  - Read-after-write hazards on S are resolved by sequencing. No stale reads permitted.
- Validity: byte is valid iff 8'h61..8'h7A or 8'h20.
  - search_en=1: first invalid byte -> NEXT_KEY without writing that byte. Partial D contents are don't-care.
  - search_en=1: k reaching MSG_LEN with all bytes valid -> DONE, found=1.
  - search_en=0: all MSG_LEN bytes written regardless. DONE; found=1 iff all bytes were valid.
- NEXT_KEY: if key_out==key_last -> DONE, found=0. Else key_out+1 and return to INIT. Never wraps past key_last, including key_last=2^KEY_BITS-1.
- stop:
  - Sampled every cycle while busy. Enters DONE on the next edge with found=0; key_out holds the key in progress. Any in-flight S/D write may complete.
  - Ignored in IDLE/DONE.
  - Simultaneous stop and successful final byte: found=1 wins.
- DONE: busy=0, done=1, all wren=0. found and key_out held stable until next start.

Test Plan:
- Single mode, key 24'h000249, MSG_LEN=32, known ciphertext -> D matches reference-model plaintext byte-exact; done=1, found=1, key_out=24'h000249.
- Search 24'h000240..24'h00024F with answer 24'h000249 -> done, found=1, key_out=24'h000249; keys 240..248 each abort before writing an invalid byte.
- Search range containing no valid key, 24'h000000..24'h000003 -> found=0, key_out=24'h000003, exactly 4 INIT passes.
- key_first=key_last=24'hFFFFFF, wrong key -> found=0, key_out=24'hFFFFFF, no wrap to 0; key_first>key_last -> done 1 cycle after start, found=0.
- stop asserted mid-KSA -> done next cycle, found=0, busy=0; start pulsed mid-run is ignored; new start from DONE clears done the following cycle.
- reset asserted mid-PRGA -> all outputs 0 immediately (async); subsequent single-mode run gives correct plaintext.
